// File: rtl/gate_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// gate_arbiter_pkg
// Shared definitions for the occupancy gate arbiter:
//   - state_t     : arbiter FSM state encoding (IDLE, SERVE, HOLD)
//   - WHO_IN/OUT  : requester identifiers used for grant and last_who
//   - MAX_COUNT_DEFAULT : default occupancy ceiling
// -----------------------------------------------------------------------------
package gate_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SERVE = 2'd1,
        HOLD  = 2'd2
    } state_t;

    localparam logic WHO_IN  = 1'b1;
    localparam logic WHO_OUT = 1'b0;

    localparam int MAX_COUNT_DEFAULT = 100;

endpackage

// File: rtl/gate_arbiter_bcd_split.sv
// -----------------------------------------------------------------------------
// bcd_split
// Purely combinational binary-to-BCD split of an unsigned value into
// hundreds / tens / units digits. Valid for values 0..999.
// Ports:
//   value    [WIDTH-1:0] in  : binary value
//   hundreds [3:0]       out : value / 100
//   tens     [3:0]       out : (value / 10) % 10
//   units    [3:0]       out : value % 10
// -----------------------------------------------------------------------------
module bcd_split #(
    parameter int WIDTH = 7
) (
    input  logic [WIDTH-1:0] value,
    output logic [3:0]       hundreds,
    output logic [3:0]       tens,
    output logic [3:0]       units
);

    logic [31:0] v;

    always_comb begin
        v        = 32'(value);
        hundreds = 4'((v / 32'd100) % 32'd10);
        tens     = 4'((v / 32'd10) % 32'd10);
        units    = 4'(v % 32'd10);
    end

endmodule

// File: rtl/gate_arbiter.sv
// -----------------------------------------------------------------------------
// gate_arbiter
// Shares one saturating occupancy counter between an entry gate (increment)
// and an exit gate (decrement). Simultaneous requests are arbitrated
// round-robin, each serviced request gets a one-cycle ack or nack, and every
// service is followed by HOLD_CYCLES idle cycles. The count is presented as
// binary and as BCD digits for the display driver.
// Ports:
//   clock, reset            : system clock, synchronous active-high reset
//   in_req / out_req        : entry / exit request levels
//   in_ack / in_nack        : entry performed / rejected (count full), pulse
//   out_ack / out_nack      : exit performed / rejected (count empty), pulse
//   busy                    : arbiter not in IDLE
//   last_who                : most recent grant, 1 = entry, 0 = exit
//   count [WIDTH-1:0]       : current occupancy
//   full / empty            : count at ceiling / at zero
//   hundreds, tens, units   : BCD digits of count
// -----------------------------------------------------------------------------
module gate_arbiter
    import gate_arbiter_pkg::*;
#(
    parameter int MAX_COUNT   = MAX_COUNT_DEFAULT,
    parameter int WIDTH       = 7,
    parameter int HOLD_CYCLES = 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_req,
    input  logic             out_req,
    output logic             in_ack,
    output logic             in_nack,
    output logic             out_ack,
    output logic             out_nack,
    output logic             busy,
    output logic             last_who,
    output logic [WIDTH-1:0] count,
    output logic             full,
    output logic             empty,
    output logic [3:0]       hundreds,
    output logic [3:0]       tens,
    output logic [3:0]       units
);

    localparam int               HOLD_W    = (HOLD_CYCLES > 0) ? $clog2(HOLD_CYCLES + 1) : 1;
    localparam logic [WIDTH-1:0] MAX_VAL   = WIDTH'(MAX_COUNT);
    localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_CYCLES);

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  count_q, count_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic              grant_q, grant_d;
    logic              last_who_q, last_who_d;
    logic              in_armed_q, in_armed_d;
    logic              out_armed_q, out_armed_d;
    logic              in_ack_q, in_ack_d;
    logic              in_nack_q, in_nack_d;
    logic              out_ack_q, out_ack_d;
    logic              out_nack_q, out_nack_d;

    logic              in_elig;
    logic              out_elig;
    logic              granted_in;
    logic              granted_out;

    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        hold_d      = hold_q;
        grant_d     = grant_q;
        last_who_d  = last_who_q;
        in_ack_d    = 1'b0;
        in_nack_d   = 1'b0;
        out_ack_d   = 1'b0;
        out_nack_d  = 1'b0;
        granted_in  = 1'b0;
        granted_out = 1'b0;

        // A held request is serviced once; it must drop before it is eligible again.
        in_elig  = in_req & in_armed_q;
        out_elig = out_req & out_armed_q;

        case (state_q)
            IDLE: begin
                if (in_elig || out_elig) begin
                    if (in_elig && out_elig) begin
                        // Tie: the side that did not win last time goes first.
                        grant_d = ~last_who_q;
                    end else if (in_elig) begin
                        grant_d = WHO_IN;
                    end else begin
                        grant_d = WHO_OUT;
                    end
                    last_who_d  = grant_d;
                    granted_in  = (grant_d == WHO_IN);
                    granted_out = (grant_d == WHO_OUT);
                    state_d     = SERVE;
                end
            end

            SERVE: begin
                if (grant_q == WHO_IN) begin
                    if (count_q < MAX_VAL) begin
                        count_d  = count_q + WIDTH'(1);
                        in_ack_d = 1'b1;
                    end else begin
                        in_nack_d = 1'b1;
                    end
                end else begin
                    if (count_q != '0) begin
                        count_d   = count_q - WIDTH'(1);
                        out_ack_d = 1'b1;
                    end else begin
                        out_nack_d = 1'b1;
                    end
                end
                if (HOLD_CYCLES > 0) begin
                    state_d = HOLD;
                    hold_d  = HOLD_LOAD;
                end else begin
                    state_d = IDLE;
                end
            end

            HOLD: begin
                if (hold_q <= HOLD_W'(1)) begin
                    hold_d  = '0;
                    state_d = IDLE;
                end else begin
                    hold_d = hold_q - HOLD_W'(1);
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        // Re-arm whenever the request is seen low; a grant only happens while
        // the request is high, so the two never collide.
        in_armed_d  = in_req  ? (in_armed_q  & ~granted_in)  : 1'b1;
        out_armed_d = out_req ? (out_armed_q & ~granted_out) : 1'b1;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= IDLE;
            count_q     <= '0;
            hold_q      <= '0;
            grant_q     <= WHO_OUT;
            last_who_q  <= WHO_OUT;
            in_armed_q  <= 1'b1;
            out_armed_q <= 1'b1;
            in_ack_q    <= 1'b0;
            in_nack_q   <= 1'b0;
            out_ack_q   <= 1'b0;
            out_nack_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            hold_q      <= hold_d;
            grant_q     <= grant_d;
            last_who_q  <= last_who_d;
            in_armed_q  <= in_armed_d;
            out_armed_q <= out_armed_d;
            in_ack_q    <= in_ack_d;
            in_nack_q   <= in_nack_d;
            out_ack_q   <= out_ack_d;
            out_nack_q  <= out_nack_d;
        end
    end

    assign in_ack   = in_ack_q;
    assign in_nack  = in_nack_q;
    assign out_ack  = out_ack_q;
    assign out_nack = out_nack_q;
    assign busy     = (state_q != IDLE);
    assign last_who = last_who_q;
    assign count    = count_q;
    assign full     = (count_q == MAX_VAL);
    assign empty    = (count_q == '0);

    bcd_split #(
        .WIDTH (WIDTH)
    ) u_bcd_split (
        .value    (count_q),
        .hundreds (hundreds),
        .tens     (tens),
        .units    (units)
    );

endmodule

// File: tb/tb_gate_arbiter.sv
// -----------------------------------------------------------------------------
// tb_gate_arbiter
// Scoreboard bench for gate_arbiter. A timestamp-based reference model
// predicts, at each sampling edge, which request is granted, the outcome, the
// edge at which the response appears and when the arbiter becomes free again;
// responses are queued and a separate monitor pops and compares them as the
// DUT presents them. Count, flags, digits, busy and last_who are checked
// every cycle against the model.
// -----------------------------------------------------------------------------
module tb_gate_arbiter;

    localparam int MAX_COUNT   = 100;
    localparam int WIDTH       = 7;
    localparam int HOLD_CYCLES = 2;

    logic             clock = 1'b0;
    logic             reset;
    logic             in_req;
    logic             out_req;
    logic             in_ack;
    logic             in_nack;
    logic             out_ack;
    logic             out_nack;
    logic             busy;
    logic             last_who;
    logic [WIDTH-1:0] count;
    logic             full;
    logic             empty;
    logic [3:0]       hundreds;
    logic [3:0]       tens;
    logic [3:0]       units;

    gate_arbiter #(
        .MAX_COUNT   (MAX_COUNT),
        .WIDTH       (WIDTH),
        .HOLD_CYCLES (HOLD_CYCLES)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .in_req   (in_req),
        .out_req  (out_req),
        .in_ack   (in_ack),
        .in_nack  (in_nack),
        .out_ack  (out_ack),
        .out_nack (out_nack),
        .busy     (busy),
        .last_who (last_who),
        .count    (count),
        .full     (full),
        .empty    (empty),
        .hundreds (hundreds),
        .tens     (tens),
        .units    (units)
    );

    always #5 clock = ~clock;

    // Response encoding: {in_ack, in_nack, out_ack, out_nack}
    typedef struct {
        int         cyc;
        logic [3:0] resp;
    } exp_t;

    exp_t exp_q[$];

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    bit sim_done = 1'b0;

    // Reference model state (visible after the most recent edge)
    int m_cnt      = 0;
    bit m_arm_in   = 1'b1;
    bit m_arm_out  = 1'b1;
    bit m_lw       = 1'b0;
    int m_free     = 0;     // first edge at which a new grant may happen
    int m_grant_at = -100;  // edge of the most recent grant
    bit m_pend     = 1'b0;
    int m_pend_cyc = 0;
    int m_pend_cnt = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at edge %0d: got %0d expected %0d", name, cyc - 1, act, exp);
        end
    endtask

    // Reference model: evaluated on every rising edge from the sampled inputs.
    always @(posedge clock) begin : model
        bit         ei;
        bit         eo;
        bit         who;
        int         nc;
        logic [3:0] r;
        exp_t       e;
        if (reset) begin
            m_cnt     = 0;
            m_arm_in  = 1'b1;
            m_arm_out = 1'b1;
            m_lw      = 1'b0;
            m_free    = cyc + 1;
            m_grant_at = -100;
            m_pend    = 1'b0;
            exp_q.delete();
        end else begin
            if (m_pend && m_pend_cyc == cyc) begin
                m_cnt  = m_pend_cnt;
                m_pend = 1'b0;
            end
            ei = in_req && m_arm_in;
            eo = out_req && m_arm_out;
            if (cyc >= m_free && (ei || eo)) begin
                who  = (ei && eo) ? !m_lw : ei;
                m_lw = who;
                if (who) begin
                    if (m_cnt < MAX_COUNT) begin nc = m_cnt + 1; r = 4'b1000; end
                    else begin nc = m_cnt; r = 4'b0100; end
                    m_arm_in = 1'b0;
                end else begin
                    if (m_cnt > 0) begin nc = m_cnt - 1; r = 4'b0010; end
                    else begin nc = m_cnt; r = 4'b0001; end
                    m_arm_out = 1'b0;
                end
                m_pend     = 1'b1;
                m_pend_cyc = cyc + 1;
                m_pend_cnt = nc;
                e.cyc      = cyc + 1;
                e.resp     = r;
                exp_q.push_back(e);
                m_grant_at = cyc;
                m_free     = cyc + 2 + HOLD_CYCLES;
            end
            if (!in_req)  m_arm_in  = 1'b1;
            if (!out_req) m_arm_out = 1'b1;
        end
        cyc++;
    end

    // Monitor: compares DUT outputs against the model mid-cycle.
    always @(negedge clock) begin : monitor
        int         e;
        int         v;
        int         h;
        int         t;
        logic [3:0] resp;
        exp_t       x;
        if (cyc > 0 && !sim_done) begin
            e = cyc - 1;
            v = m_cnt;
            h = 0;
            t = 0;
            while (v >= 100) begin v -= 100; h++; end
            while (v >= 10)  begin v -= 10;  t++; end
            check("count", int'(count), m_cnt);
            check("full", int'(full), int'(m_cnt == MAX_COUNT));
            check("empty", int'(empty), int'(m_cnt == 0));
            check("hundreds", int'(hundreds), h);
            check("tens", int'(tens), t);
            check("units", int'(units), v);
            check("busy", int'(busy), int'(e >= m_grant_at && e < m_free - 1));
            check("last_who", int'(last_who), int'(m_lw));
            resp = {in_ack, in_nack, out_ack, out_nack};
            if (resp != 4'b0000) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_resp", int'(resp), 0);
                end else begin
                    x = exp_q.pop_front();
                    check("resp_edge", e, x.cyc);
                    check("resp_kind", int'(resp), int'(x.resp));
                end
            end else if (exp_q.size() > 0 && exp_q[0].cyc <= e) begin
                x = exp_q.pop_front();
                check("missing_resp", 0, int'(x.resp));
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic do_reset();
        reset   = 1'b1;
        in_req  = 1'b0;
        out_req = 1'b0;
        tick(2);
        reset = 1'b0;
    endtask

    task automatic pulse_in();
        in_req = 1'b1;
        tick(1);
        in_req = 1'b0;
        tick(4);
    endtask

    initial begin
        reset   = 1'b1;
        in_req  = 1'b0;
        out_req = 1'b0;
        tick(2);
        check("reset_count", int'(count), 0);
        check("reset_empty", int'(empty), 1);
        check("reset_busy", int'(busy), 0);
        reset = 1'b0;

        // Held entry request: serviced exactly once.
        in_req = 1'b1;
        tick(1);
        tick(1);
        check("t1_in_ack", int'(in_ack), 1);
        tick(3);
        in_req = 1'b0;
        tick(4);
        check("t1_count", int'(count), 1);

        // Exit from empty: nack, count stays 0.
        do_reset();
        out_req = 1'b1;
        tick(1);
        out_req = 1'b0;
        tick(1);
        check("t2_out_nack", int'(out_nack), 1);
        tick(4);
        check("t2_count", int'(count), 0);

        // Both held: entry first, exit after hold, then nothing more.
        do_reset();
        in_req  = 1'b1;
        out_req = 1'b1;
        tick(14);
        check("t3_count", int'(count), 0);
        check("t3_last_who", int'(last_who), 0);
        in_req  = 1'b0;
        out_req = 1'b0;
        tick(4);

        // Fill to the ceiling, then one more.
        do_reset();
        repeat (MAX_COUNT) pulse_in();
        check("t4_count", int'(count), MAX_COUNT);
        check("t4_full", int'(full), 1);
        check("t4_hundreds", int'(hundreds), 1);
        in_req = 1'b1;
        tick(2);
        check("t4_in_nack", int'(in_nack), 1);
        in_req = 1'b0;
        tick(4);
        check("t4_count_hold", int'(count), MAX_COUNT);

        // Reset on the SERVE edge of an entry request.
        do_reset();
        repeat (57) pulse_in();
        check("t5_count57", int'(count), 57);
        in_req = 1'b1;
        tick(1);
        reset  = 1'b1;
        in_req = 1'b0;
        tick(1);
        check("t5_count", int'(count), 0);
        check("t5_in_ack", int'(in_ack), 0);
        check("t5_busy", int'(busy), 0);
        reset = 1'b0;
        tick(3);

        // Digits at 57, then one exit.
        do_reset();
        repeat (57) pulse_in();
        check("t6_tens", int'(tens), 5);
        check("t6_units", int'(units), 7);
        out_req = 1'b1;
        tick(1);
        out_req = 1'b0;
        tick(1);
        check("t6_out_ack", int'(out_ack), 1);
        check("t6_count", int'(count), 56);
        tick(4);

        // Randomized traffic, biased toward filling then draining.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            if (i < 1500) begin
                in_req  = ($urandom_range(0, 3) != 0);
                out_req = ($urandom_range(0, 3) == 0);
            end else begin
                in_req  = ($urandom_range(0, 3) == 0);
                out_req = ($urandom_range(0, 3) != 0);
            end
            reset = ($urandom_range(0, 499) == 0);
            tick(1);
        end
        reset   = 1'b0;
        in_req  = 1'b0;
        out_req = 1'b0;
        tick(8);
        check("pending_responses", exp_q.size(), 0);

        sim_done = 1'b1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
